// File: rtl/best_arr_sender_if.sv
// Interface bundling the start/status, best-array SRAM read and output FIFO push signals of
// best_arr_sender.
//   master : the sender (drives SRAM reads, FIFO pushes and status)
//   slave  : the environment (core control, SRAMs, FIFO)
// Signals:
//   send_best_arr    start pulse
//   best_arr_csb     SRAM chip select, active low
//   best_arr_addr    SRAM read address
//   best_idx_rdata   best index read data (1-cycle latency)
//   best_dist_rdata  best distance read data (1-cycle latency)
//   out_fifo_wenq    FIFO push strobe
//   out_fifo_wdata   FIFO push data
//   out_fifo_wfull_n FIFO not full
//   busy             pass in progress
//   send_done        sticky pass-complete flag
interface best_arr_sender_if #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                    send_best_arr;
    logic                    best_arr_csb;
    logic [ADDR_WIDTH-1:0]   best_arr_addr;
    logic [DATA_WIDTH-1:0]   best_idx_rdata;
    logic [2*DATA_WIDTH-1:0] best_dist_rdata;
    logic                    out_fifo_wenq;
    logic [DATA_WIDTH-1:0]   out_fifo_wdata;
    logic                    out_fifo_wfull_n;
    logic                    busy;
    logic                    send_done;

    modport master (
        input  send_best_arr,
        output best_arr_csb,
        output best_arr_addr,
        input  best_idx_rdata,
        input  best_dist_rdata,
        output out_fifo_wenq,
        output out_fifo_wdata,
        input  out_fifo_wfull_n,
        output busy,
        output send_done
    );

    modport slave (
        output send_best_arr,
        input  best_arr_csb,
        input  best_arr_addr,
        output best_idx_rdata,
        output best_dist_rdata,
        input  out_fifo_wenq,
        input  out_fifo_wdata,
        output out_fifo_wfull_n,
        input  busy,
        input  send_done
    );
endinterface

// File: rtl/best_arr_sender.sv
// Output-stage serializer: on a start pulse, walks every query slot of the best-match SRAMs in
// host readback order and pushes the best index (and optionally the best distance as two words)
// into the output FIFO, then raises a sticky send_done.
// Ports:
//   io_clk    clock
//   io_rst_n  asynchronous active-low reset
//   bus       best_arr_sender_if.master (start/status, SRAM read port, FIFO push port)
// Configuration macro:
//   BEST_DIST_SEND_EN  when defined, an index phase is followed by a distance phase
//                      (low half then high half per slot); otherwise index phase only.
module best_arr_sender #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned ROW_SIZE   = 32,
    parameter int unsigned COL_SIZE   = 16,
    parameter int unsigned BLOCKING   = 4
) (
    input  logic               io_clk,
    input  logic               io_rst_n,
    best_arr_sender_if.master  bus
);
    localparam int unsigned NUM_QUERYS = ROW_SIZE * COL_SIZE;
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_QUERYS);
    localparam int unsigned X_COUNT    = ROW_SIZE / 2 / BLOCKING;
    localparam int unsigned XW         = (X_COUNT > 1) ? $clog2(X_COUNT) : 1;
    localparam int unsigned YW         = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int unsigned XIW        = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StPushLo,
        StPushHi,
        StNext,
        StDone
    } state_e;

    state_e                  state_q;
    logic                    csb_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    // Slot counters, innermost xi to outermost px.
    logic                    px_q, px_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [XIW-1:0]          xi_q, xi_d;
    logic                    last_slot;

`ifdef BEST_DIST_SEND_EN
    logic                    phase_q;    // 0: index phase, 1: distance phase
    logic [DATA_WIDTH-1:0]   dist_hi_q;
`else
    logic                    unused_dist;
    assign unused_dist = ^bus.best_dist_rdata;
`endif

    always_comb begin
        logic xi_wrap, y_wrap, x_wrap;
        xi_wrap   = (xi_q == XIW'(BLOCKING - 1));
        y_wrap    = (y_q == YW'(COL_SIZE - 1));
        x_wrap    = (x_q == XW'(X_COUNT - 1));
        last_slot = xi_wrap && y_wrap && x_wrap && px_q;

        xi_d = xi_wrap ? '0 : xi_q + 1'b1;
        y_d  = y_q;
        x_d  = x_q;
        px_d = px_q;
        if (xi_wrap) begin
            y_d = y_wrap ? '0 : y_q + 1'b1;
            if (y_wrap) begin
                x_d = x_wrap ? '0 : x_q + 1'b1;
                if (x_wrap) begin
                    px_d = ~px_q;
                end
            end
        end
    end

    // px selects the right half of the row; x/xi walk a block-column, y steps whole rows.
    assign bus.best_arr_addr = ADDR_WIDTH'(32'(px_q) * (ROW_SIZE / 2) + 32'(y_q) * ROW_SIZE
                                           + 32'(x_q) * BLOCKING + 32'(xi_q));

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_q   <= StIdle;
            csb_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wdata_q   <= '0;
            px_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            xi_q      <= '0;
`ifdef BEST_DIST_SEND_EN
            phase_q   <= 1'b0;
            dist_hi_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.send_best_arr) begin
                        state_q <= StRead;
                        csb_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        px_q    <= 1'b0;
                        x_q     <= '0;
                        y_q     <= '0;
                        xi_q    <= '0;
`ifdef BEST_DIST_SEND_EN
                        phase_q <= 1'b0;
`endif
                    end
                end
                StRead: begin
                    csb_q   <= 1'b1;
                    state_q <= StLatch;
                end
                StLatch: begin
                    state_q <= StPushLo;
`ifdef BEST_DIST_SEND_EN
                    if (phase_q) begin
                        wdata_q   <= bus.best_dist_rdata[DATA_WIDTH-1:0];
                        dist_hi_q <= bus.best_dist_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
                    end else begin
                        wdata_q   <= bus.best_idx_rdata;
                    end
`else
                    wdata_q <= bus.best_idx_rdata;
`endif
                end
                StPushLo: begin
                    if (bus.out_fifo_wfull_n) begin
`ifdef BEST_DIST_SEND_EN
                        if (phase_q) begin
                            wdata_q <= dist_hi_q;
                            state_q <= StPushHi;
                        end else begin
                            state_q <= StNext;
                        end
`else
                        state_q <= StNext;
`endif
                    end
                end
`ifdef BEST_DIST_SEND_EN
                StPushHi: begin
                    if (bus.out_fifo_wfull_n) begin
                        state_q <= StNext;
                    end
                end
`endif
                StNext: begin
                    px_q <= px_d;
                    x_q  <= x_d;
                    y_q  <= y_d;
                    xi_q <= xi_d;
`ifdef BEST_DIST_SEND_EN
                    // Counters wrap to zero on the last slot, so the distance phase restarts at 0.
                    if (last_slot && phase_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        if (last_slot) begin
                            phase_q <= 1'b1;
                        end
                        state_q <= StRead;
                        csb_q   <= 1'b0;
                    end
`else
                    if (last_slot) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StRead;
                        csb_q   <= 1'b0;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Push only when the FIFO has room; data is held in wdata_q across stalls.
    assign bus.out_fifo_wenq  = bus.out_fifo_wfull_n &&
                                ((state_q == StPushLo) || (state_q == StPushHi));
    assign bus.out_fifo_wdata = wdata_q;
    assign bus.best_arr_csb   = csb_q;
    assign bus.busy           = busy_q;
    assign bus.send_done      = done_q;
endmodule
